// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption engine.
// One cipher round is applied per clock.
// The round key is expanded on the fly alongside the state.
// The start/done handshake connects the plaintext/key front end
// to the ciphertext output path.
//
// state | meaning
// IDLE  | waiting for startEncryption; cipherText holds the last result
// ROUND | full rounds 1..9 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// FINAL | last round without MixColumns; result registered, done pulsed

// Single AES S-box lookup.
// The multiplicative inverse is computed as x^254 in GF(2^8),
// followed by the affine transform.
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // Addition chain for x^254; zero maps to zero naturally.
    assign x2   = gf_mul(in_byte, in_byte);
    assign x3   = gf_mul(x2, in_byte);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign inv  = gf_mul(gf_mul(x240, x12), x2);

    assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// SubBytes over a full 128-bit block: 16 parallel S-boxes, purely combinational.
module sub_byte (
    input  logic [127:0] in_block,
    output logic [127:0] out_block
);
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        s_box u_sbox (
            .in_byte  (in_block[127-8*i -: 8]),
            .out_byte (out_block[127-8*i -: 8])
        );
    end
endmodule

module aes_round_controller #(
    parameter int ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         startEncryption,
    input  logic [127:0] plainText,
    input  logic [127:0] cipherKey,
    output logic [127:0] cipherText,
    output logic         busy,
    output logic         encryptionDone,
    output logic [3:0]   roundCount
);
    if (ROUNDS != 10) begin : g_rounds_check
        $error("aes_round_controller supports AES-128 only (ROUNDS must be 10)");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t       state, state_nxt;
    logic [127:0] state_reg, key_reg, cipher_q;
    logic [7:0]   rcon_reg;
    logic [3:0]   round_cnt;
    logic         busy_q, done_q;
    logic         load_en, round_en, final_en;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte index 4c+r is row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic [127:0] sb_state, sr_state, mc_state, next_key;
    logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7, rot_word, sub_word;

    sub_byte u_sub_byte (.in_block(state_reg), .out_block(sb_state));

    assign sr_state = shift_rows(sb_state);
    assign mc_state = mix_columns(sr_state);

    assign w0       = key_reg[127:96];
    assign w1       = key_reg[95:64];
    assign w2       = key_reg[63:32];
    assign w3       = key_reg[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    s_box u_key_sbox0 (.in_byte(rot_word[31:24]), .out_byte(sub_word[31:24]));
    s_box u_key_sbox1 (.in_byte(rot_word[23:16]), .out_byte(sub_word[23:16]));
    s_box u_key_sbox2 (.in_byte(rot_word[15:8]),  .out_byte(sub_word[15:8]));
    s_box u_key_sbox3 (.in_byte(rot_word[7:0]),   .out_byte(sub_word[7:0]));

    assign w4       = w0 ^ sub_word ^ {rcon_reg, 24'h0};
    assign w5       = w1 ^ w4;
    assign w6       = w2 ^ w5;
    assign w7       = w3 ^ w6;
    assign next_key = {w4, w5, w6, w7};

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (startEncryption) state_nxt = ROUND;
            ROUND:   if (round_cnt == 4'(ROUNDS - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for the current state.
    always_comb begin
        load_en  = 1'b0;
        round_en = 1'b0;
        final_en = 1'b0;
        case (state)
            IDLE:    load_en  = startEncryption;
            ROUND:   round_en = 1'b1;
            FINAL:   final_en = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture, per-round state/key update, final result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcon_reg  <= '0;
            round_cnt <= '0;
            cipher_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= final_en;
            if (load_en) begin
                state_reg <= plainText ^ cipherKey;
                key_reg   <= cipherKey;
                rcon_reg  <= 8'h01;
                round_cnt <= 4'd1;
                busy_q    <= 1'b1;
            end else if (round_en) begin
                state_reg <= mc_state ^ next_key;
                key_reg   <= next_key;
                rcon_reg  <= xtime(rcon_reg);
                round_cnt <= round_cnt + 4'd1;
            end else if (final_en) begin
                cipher_q  <= sr_state ^ next_key;
                round_cnt <= 4'd0;
                busy_q    <= 1'b0;
            end
        end
    end

    assign cipherText     = cipher_q;
    assign busy           = busy_q;
    assign encryptionDone = done_q;
    assign roundCount     = round_cnt;
endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller.
// Uses known-answer vectors, a byte-array AES-128 reference model,
// and randomized blocks.
module tb_aes_round_controller;
    logic         clock;
    logic         reset;
    logic         startEncryption;
    logic [127:0] plainText;
    logic [127:0] cipherKey;
    logic [127:0] cipherText;
    logic         busy;
    logic         encryptionDone;
    logic [3:0]   roundCount;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_round_controller #(.ROUNDS(10)) dut (
        .clock           (clock),
        .reset           (reset),
        .startEncryption (startEncryption),
        .plainText       (plainText),
        .cipherKey       (cipherKey),
        .cipherText      (cipherText),
        .busy            (busy),
        .encryptionDone  (encryptionDone),
        .roundCount      (roundCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = ref_gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = ref_gmul(a0, 8'h02) ^ ref_gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ ref_gmul(a1, 8'h02) ^ ref_gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ ref_gmul(a2, 8'h02) ^ ref_gmul(a3, 8'h03);
                    s[4*c+3] = ref_gmul(a0, 8'h03) ^ a1 ^ a2 ^ ref_gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = s[4*c+row] ^ w[4*rnd+c][31-8*row -: 8];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 1: inputs scrambled every cycle after capture plus a start pulse at round 4.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp, input int mode, input string tag);
        int edges, busy_cnt;
        plainText       = pt;
        cipherKey       = key;
        startEncryption = 1'b1;
        tick();
        edges           = 1;
        busy_cnt        = 0;
        startEncryption = 1'b0;
        while (!encryptionDone && edges < 20) begin
            if (busy) busy_cnt++;
            check({tag, "_round"}, 128'(roundCount), 128'(edges));
            if (mode == 1) begin
                plainText       = rand128();
                cipherKey       = rand128();
                startEncryption = (edges == 4);
            end
            tick();
            edges++;
        end
        startEncryption = 1'b0;
        check({tag, "_latency"}, 128'(edges), 128'd11);
        check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
        check({tag, "_ct"}, cipherText, exp);
        check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
        check({tag, "_round_at_done"}, 128'(roundCount), 128'd0);
        tick();
        check({tag, "_done_width"}, 128'(encryptionDone), 128'd0);
        check({tag, "_idle_after"}, 128'(busy), 128'd0);
        check({tag, "_ct_held"}, cipherText, exp);
    endtask

    initial begin
        logic [127:0] exp_q [$];
        int           done_at [$];
        logic [127:0] vp [2];
        logic [127:0] vk [2];
        logic [127:0] vc [2];
        logic [127:0] rp, rk;
        int           k, guard, done_cnt;

        reset           = 1'b1;
        startEncryption = 1'b0;
        plainText       = '0;
        cipherKey       = '0;
        build_sbox();
        tick();
        tick();
        check("rst_ct", cipherText, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(encryptionDone), 128'd0);
        check("rst_round", 128'(roundCount), 128'd0);
        reset = 1'b0;
        tick();

        run_block(PT_B, KEY_B, CT_B, 0, "fips_b");
        run_block(PT_C, KEY_C, CT_C, 0, "fips_c1");
        run_block(PT_B, KEY_B, CT_B, 1, "scramble");

        // Start held high: blocks run back to back, alternating vectors.
        vp[0] = PT_B; vk[0] = KEY_B; vc[0] = CT_B;
        vp[1] = PT_C; vk[1] = KEY_C; vc[1] = CT_C;
        k = 0;
        for (int i = 0; i < 70; i++) begin
            startEncryption = (i < 30);
            if (startEncryption && !busy) begin
                plainText = vp[k%2];
                cipherKey = vk[k%2];
                exp_q.push_back(vc[k%2]);
                k++;
            end
            tick();
            if (encryptionDone) begin
                done_at.push_back(i);
                if (exp_q.size() > 0) check("b2b_ct", cipherText, exp_q.pop_front());
                else check("b2b_spurious_done", 128'(encryptionDone), 128'd0);
            end
        end
        startEncryption = 1'b0;
        check("b2b_blocks", 128'(k), 128'd3);
        check("b2b_dones", 128'(done_at.size()), 128'd3);
        check("b2b_pending", 128'(exp_q.size()), 128'd0);
        for (int i = 1; i < done_at.size(); i++)
            check("b2b_spacing", 128'(done_at[i] - done_at[i-1]), 128'd11);

        // Asynchronous reset in the middle of round 6.
        plainText       = PT_B;
        cipherKey       = KEY_B;
        startEncryption = 1'b1;
        tick();
        startEncryption = 1'b0;
        guard = 0;
        while (roundCount != 4'd6 && guard < 20) begin
            tick();
            guard++;
        end
        check("abort_reach_r6", 128'(roundCount), 128'd6);
        #3 reset = 1'b1;
        #1;
        check("abort_ct", cipherText, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(encryptionDone), 128'd0);
        check("abort_round", 128'(roundCount), 128'd0);
        tick();
        tick();
        reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (encryptionDone) done_cnt++;
        end
        check("abort_no_done", 128'(done_cnt), 128'd0);
        check("abort_ct_kept_zero", cipherText, 128'd0);
        run_block(PT_B, KEY_B, CT_B, 0, "after_abort");

        // All-zero key and plaintext, then the result must hold while idle.
        run_block(128'd0, 128'd0, CT_Z, 0, "zero");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("zero_hold", cipherText, CT_Z);
        end

        // Randomized blocks against the reference model.
        for (int n = 0; n < 8; n++) begin
            rp = rand128();
            rk = rand128();
            run_block(rp, rk, aes_ref(rp, rk), n % 2, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
